// File: rtl/wb_stream_writer.sv
// wb_stream_writer: Wishbone master DMA that reads a memory buffer in
// incrementing bursts, buffers the words in a FIFO and emits them on a
// 32-bit valid/ready stream. Configured through a small Wishbone slave.
module wb_stream_writer #(
  parameter int WB_DW       = 32,
  parameter int WB_AW       = 32,
  parameter int FIFO_AW     = 7,
  parameter int MAX_BURST_W = 8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n_i,
  output logic [WB_AW-1:0] wbm_adr_o,
  output logic [WB_DW-1:0] wbm_dat_o,
  output logic [3:0]       wbm_sel_o,
  output logic             wbm_we_o,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic [2:0]       wbm_cti_o,
  output logic [1:0]       wbm_bte_o,
  input  logic [WB_DW-1:0] wbm_dat_i,
  input  logic             wbm_ack_i,
  input  logic             wbm_err_i,
  output logic [WB_DW-1:0] stream_m_data_o,
  output logic             stream_m_valid_o,
  input  logic             stream_m_ready_i,
  output logic             irq_o,
  input  logic [4:0]       wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic             wbs_we_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_stb_i,
  output logic [31:0]      wbs_dat_o,
  output logic             wbs_ack_o
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW+1)'(DEPTH);
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BURST = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // Byte-lane merge for register writes.
  function automatic logic [31:0] merge_sel(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  sel);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = sel[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return res;
  endfunction

  state_t                 state_r, state_nxt_s;
  logic                   wbs_ack_r;
  logic [31:0]            wbs_dat_r, rd_mux_s;
  logic                   done_r, err_r, irq_r;
  logic [31:0]            start_adr_r, buf_size_r;
  logic [MAX_BURST_W-1:0] burst_size_r, burst_lat_r, beats_r;
  logic [WB_AW-1:0]       adr_r;
  logic [31:0]            remaining_r;
  logic                   cyc_r;
  logic [2:0]             cti_r;
  logic [WB_DW-1:0]       fifo_mem_r [DEPTH];
  logic [FIFO_AW-1:0]     wr_ptr_r, rd_ptr_r;
  logic [FIFO_AW:0]       fifo_cnt_r, free_s;
  logic [WB_DW-1:0]       out_data_r;
  logic                   out_valid_r;

  logic                   slv_acc_s, slv_wr_s, start_req_s;
  logic [1:0]             clr_s;
  logic [MAX_BURST_W-1:0] bsz_eff_s, blen_s;
  logic                   latch_s, launch_s, beat_s, last_beat_s, bus_err_s, set_done_s;
  logic                   pop_s;
  logic                   done_nxt_s, err_nxt_s;

  assign slv_acc_s   = wbs_cyc_i & wbs_stb_i & ~wbs_ack_r;
  assign slv_wr_s    = slv_acc_s & wbs_we_i;
  assign start_req_s = slv_wr_s && (wbs_adr_i == 5'h00) && wbs_sel_i[0] && wbs_dat_i[0];
  assign clr_s       = (slv_wr_s && (wbs_adr_i == 5'h04) && wbs_sel_i[0]) ? wbs_dat_i[1:0] : 2'b00;

  // A zero burst size behaves as single-word bursts; the tail burst is clipped.
  assign bsz_eff_s = (burst_lat_r == '0) ? MAX_BURST_W'(1'b1) : burst_lat_r;
  assign blen_s    = (remaining_r < 32'(bsz_eff_s)) ? remaining_r[MAX_BURST_W-1:0] : bsz_eff_s;
  assign free_s    = DEPTH_C - fifo_cnt_r;
  assign pop_s     = (fifo_cnt_r != '0) && (!out_valid_r || stream_m_ready_i);

  assign done_nxt_s = set_done_s | (done_r & ~clr_s[0]);
  assign err_nxt_s  = bus_err_s  | (err_r  & ~clr_s[1]);

  // Register readback multiplexer.
  always_comb begin
    rd_mux_s = 32'd0;
    case (wbs_adr_i)
      5'h00:   rd_mux_s = {31'd0, (state_r != ST_IDLE)};
      5'h04:   rd_mux_s = {30'd0, err_r, done_r};
      5'h08:   rd_mux_s = start_adr_r;
      5'h0C:   rd_mux_s = buf_size_r;
      5'h10:   rd_mux_s = 32'(burst_size_r);
      default: rd_mux_s = 32'd0;
    endcase
  end

  // Slave handshake, configuration registers and sticky status.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      wbs_ack_r    <= 1'b0;
      wbs_dat_r    <= 32'd0;
      start_adr_r  <= 32'd0;
      buf_size_r   <= 32'd0;
      burst_size_r <= '0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
      irq_r        <= 1'b0;
    end else begin
      wbs_ack_r <= slv_acc_s;
      if (slv_acc_s) begin
        wbs_dat_r <= rd_mux_s;
      end
      if (slv_wr_s) begin
        case (wbs_adr_i)
          5'h08:   start_adr_r  <= merge_sel(start_adr_r, wbs_dat_i, wbs_sel_i) & 32'hFFFF_FFFC;
          5'h0C:   buf_size_r   <= merge_sel(buf_size_r, wbs_dat_i, wbs_sel_i);
          5'h10:   burst_size_r <= MAX_BURST_W'(merge_sel(32'(burst_size_r), wbs_dat_i, wbs_sel_i));
          default: ;
        endcase
      end
      // New events take priority over a simultaneous write-1-to-clear.
      done_r <= done_nxt_s;
      err_r  <= err_nxt_s;
      irq_r  <= done_nxt_s | err_nxt_s;
    end
  end

  // Master FSM state register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Master FSM next-state and control strobes.
  always_comb begin
    state_nxt_s = state_r;
    latch_s     = 1'b0;
    launch_s    = 1'b0;
    beat_s      = 1'b0;
    last_beat_s = 1'b0;
    bus_err_s   = 1'b0;
    set_done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_req_s) begin
          if (buf_size_r != 32'd0) begin
            latch_s     = 1'b1;
            state_nxt_s = ST_WAIT;
          end else begin
            set_done_s  = 1'b1;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (remaining_r == 32'd0) begin
          state_nxt_s = ST_DRAIN;
        end else if (32'(free_s) >= 32'(blen_s)) begin
          launch_s    = 1'b1;
          state_nxt_s = ST_BURST;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_BURST: begin
        if (wbm_err_i) begin
          bus_err_s   = 1'b1;
          state_nxt_s = ST_IDLE;
        end else if (wbm_ack_i) begin
          beat_s = 1'b1;
          if (beats_r == MAX_BURST_W'(1'b1)) begin
            last_beat_s = 1'b1;
            state_nxt_s = ST_WAIT;
          end else begin
            state_nxt_s = ST_BURST;
          end
        end else begin
          state_nxt_s = ST_BURST;
        end
      end
      ST_DRAIN: begin
        if ((fifo_cnt_r == '0) && !out_valid_r) begin
          set_done_s  = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Master datapath: address, word counters and registered bus controls.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      adr_r       <= '0;
      remaining_r <= 32'd0;
      burst_lat_r <= '0;
      beats_r     <= '0;
      cyc_r       <= 1'b0;
      cti_r       <= CTI_CLASSIC;
    end else if (latch_s) begin
      adr_r       <= start_adr_r[WB_AW-1:0];
      remaining_r <= buf_size_r;
      burst_lat_r <= burst_size_r;
    end else if (launch_s) begin
      cyc_r   <= 1'b1;
      beats_r <= blen_s;
      cti_r   <= (blen_s == MAX_BURST_W'(1'b1)) ? CTI_EOB : CTI_INC;
    end else if (bus_err_s) begin
      cyc_r <= 1'b0;
      cti_r <= CTI_CLASSIC;
    end else if (beat_s) begin
      adr_r       <= adr_r + WB_AW'(32'd4);
      remaining_r <= remaining_r - 32'd1;
      beats_r     <= beats_r - MAX_BURST_W'(1'b1);
      if (last_beat_s) begin
        cyc_r <= 1'b0;
        cti_r <= CTI_CLASSIC;
      end else if (beats_r == MAX_BURST_W'(2'd2)) begin
        cti_r <= CTI_EOB;
      end
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge wb_clk_i) begin
    if (beat_s) begin
      fifo_mem_r[wr_ptr_r] <= wbm_dat_i;
    end
  end

  // FIFO pointers/occupancy and the stream output register; error flushes all.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      fifo_cnt_r  <= '0;
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
    end else if (bus_err_s) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      fifo_cnt_r  <= '0;
      out_valid_r <= 1'b0;
    end else begin
      if (beat_s) begin
        wr_ptr_r <= wr_ptr_r + FIFO_AW'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r    <= rd_ptr_r + FIFO_AW'(1'b1);
        out_data_r  <= fifo_mem_r[rd_ptr_r];
        out_valid_r <= 1'b1;
      end else if (stream_m_ready_i) begin
        out_valid_r <= 1'b0;
      end
      if (beat_s && !pop_s) begin
        fifo_cnt_r <= fifo_cnt_r + (FIFO_AW+1)'(1'b1);
      end else if (!beat_s && pop_s) begin
        fifo_cnt_r <= fifo_cnt_r - (FIFO_AW+1)'(1'b1);
      end
    end
  end

  assign wbm_adr_o        = adr_r;
  assign wbm_dat_o        = '0;
  assign wbm_sel_o        = 4'hF;
  assign wbm_we_o         = 1'b0;
  assign wbm_cyc_o        = cyc_r;
  assign wbm_stb_o        = cyc_r;
  assign wbm_cti_o        = cti_r;
  assign wbm_bte_o        = 2'b00;
  assign stream_m_data_o  = out_data_r;
  assign stream_m_valid_o = out_valid_r;
  assign irq_o            = irq_r;
  assign wbs_dat_o        = wbs_dat_r;
  assign wbs_ack_o        = wbs_ack_r;

endmodule

// File: tb/tb_wb_stream_writer.sv
// Bench for wb_stream_writer: a Wishbone memory responder, a stream sink,
// and a scoreboard fed from a word/burst-level model of each transfer.
module tb_wb_stream_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_ack_i, wbm_err_i;
  logic [2:0]  wbm_cti_o;
  logic [1:0]  wbm_bte_o;
  logic [31:0] s_data;
  logic        s_valid, s_ready;
  logic        irq_o;
  logic [4:0]  wbs_adr_i;
  logic [31:0] wbs_dat_i, wbs_dat_o;
  logic [3:0]  wbs_sel_i;
  logic        wbs_we_i, wbs_cyc_i, wbs_stb_i, wbs_ack_o;

  always #5 clk = ~clk;

  wb_stream_writer dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
    .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o), .wbm_dat_i(wbm_dat_i),
    .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
    .stream_m_data_o(s_data), .stream_m_valid_o(s_valid), .stream_m_ready_i(s_ready),
    .irq_o(irq_o),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_sel_i(wbs_sel_i),
    .wbs_we_i(wbs_we_i), .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i),
    .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o)
  );

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] exp_adr_q[$];
  logic [2:0]  exp_cti_q[$];
  logic [31:0] exp_dat_q[$];
  logic [31:0] cur_start = 32'd0;
  logic [31:0] cur_base = 32'd0;
  int          beat_cnt = 0;
  int          err_at = 0;
  bit          ack_rand = 1'b0;
  int          ready_mode = 0;
  bit          hold_en = 1'b1;
  int          cyc_no = 0;
  int          first_ack = -1;
  int          first_val = -1;
  bit          cyc_seen = 1'b0;
  logic        pv = 1'b0;
  logic        pr = 1'b0;
  logic [31:0] pd = 32'd0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Memory responder: word at byte address A is cur_base + (A - cur_start)/4.
  always @(posedge clk) begin
    #2;
    wbm_ack_i = 1'b0;
    wbm_err_i = 1'b0;
    if (rst_n && wbm_cyc_o && wbm_stb_o) begin
      if (err_at != 0 && beat_cnt + 1 == err_at) begin
        wbm_err_i = 1'b1;
      end else if (!ack_rand || $urandom_range(0, 3) != 0) begin
        wbm_ack_i = 1'b1;
        wbm_dat_i = cur_base + ((wbm_adr_o - cur_start) >> 2);
        beat_cnt++;
      end
    end
  end

  // Stream sink ready pattern.
  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       s_ready = 1'b1;
      1:       s_ready = 1'b0;
      default: s_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: pops expectations whenever a bus beat or stream word is taken.
  always @(negedge clk) begin
    cyc_no++;
    if (!rst_n) begin
      pv = 1'b0;
    end else begin
      if (wbm_cyc_o) cyc_seen = 1'b1;
      if (wbm_cyc_o && wbm_stb_o && wbm_ack_i) begin
        if (first_ack < 0) first_ack = cyc_no;
        if (exp_adr_q.size() == 0) begin
          check("unexpected_beat", 32'd1, 32'd0);
        end else begin
          check("beat_adr", wbm_adr_o, exp_adr_q.pop_front());
          check("beat_cti", 32'(wbm_cti_o), 32'(exp_cti_q.pop_front()));
        end
      end
      if (hold_en && pv && !pr) begin
        check("hold_valid", 32'(s_valid), 32'd1);
        check("hold_data", s_data, pd);
      end
      if (s_valid && first_val < 0) first_val = cyc_no;
      if (s_valid && s_ready) begin
        if (exp_dat_q.size() == 0) begin
          check("unexpected_word", 32'd1, 32'd0);
        end else begin
          check("stream_data", s_data, exp_dat_q.pop_front());
        end
      end
      pv = s_valid;
      pr = s_ready;
      pd = s_data;
    end
  end

  task automatic wait_ack(input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!wbs_ack_o && n < 10);
    if (!wbs_ack_o) check(nm, 32'(wbs_ack_o), 32'd1);
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
    @(posedge clk); #2;
    wbs_adr_i = a; wbs_dat_i = d; wbs_sel_i = s; wbs_we_i = 1'b1;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    wait_ack("wbs_write_ack");
    @(posedge clk); #2;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic wb_read(input logic [4:0] a, output logic [31:0] d);
    @(posedge clk); #2;
    wbs_adr_i = a; wbs_we_i = 1'b0; wbs_sel_i = 4'hF;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    wait_ack("wbs_read_ack");
    d = wbs_dat_o;
    @(posedge clk); #2;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
  endtask

  task automatic expect_reg(input string nm, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] d;
    wb_read(a, d);
    check(nm, d, exp);
  endtask

  // Model: buffer of bs words split into bursts of max(bu,1) with a clipped tail.
  task automatic start_xfer(input logic [31:0] sa, input int unsigned bs,
                            input int unsigned bu, input logic [31:0] base);
    int unsigned rem, b, n;
    cur_start = sa; cur_base = base; beat_cnt = 0;
    first_ack = -1; first_val = -1;
    rem = bs; n = 0;
    while (rem > 0) begin
      b = (bu == 0) ? 1 : bu;
      if (b > rem) b = rem;
      for (int k = 0; k < int'(b); k++) begin
        exp_adr_q.push_back(sa + 32'(4 * n));
        exp_cti_q.push_back((k == int'(b) - 1) ? 3'b111 : 3'b010);
        exp_dat_q.push_back(base + 32'(n));
        n++;
      end
      rem -= b;
    end
    wb_write(5'h08, sa);
    wb_write(5'h0C, 32'(bs));
    wb_write(5'h10, 32'(bu));
    wb_write(5'h00, 32'd1);
  endtask

  task automatic wait_irq(input string nm, input int bound);
    int n = 0;
    while (!irq_o && n < bound) begin
      @(negedge clk);
      n++;
    end
    check(nm, 32'(irq_o), 32'd1);
  endtask

  task automatic finish_xfer(input string nm);
    expect_reg({nm, "_status"}, 5'h04, 32'd1);
    check({nm, "_beats_left"}, 32'(exp_adr_q.size()), 32'd0);
    check({nm, "_words_left"}, 32'(exp_dat_q.size()), 32'd0);
    wb_write(5'h04, 32'd3);
    check({nm, "_irq_clr"}, 32'(irq_o), 32'd0);
  endtask

  task automatic clear_model();
    exp_adr_q.delete();
    exp_cti_q.delete();
    exp_dat_q.delete();
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] base, sa;
    int          n;
    wbs_adr_i = 5'd0; wbs_dat_i = 32'd0; wbs_sel_i = 4'h0;
    wbs_we_i = 1'b0; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_dat_i = 32'd0; s_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_cyc", 32'(wbm_cyc_o), 32'd0);
    check("rst_stb", 32'(wbm_stb_o), 32'd0);
    check("rst_wbs_ack", 32'(wbs_ack_o), 32'd0);
    check("rst_valid", 32'(s_valid), 32'd0);
    check("rst_irq", 32'(irq_o), 32'd0);
    check("rst_cti", 32'(wbm_cti_o), 32'd0);
    check("rst_adr", wbm_adr_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    expect_reg("rst_ctrl", 5'h00, 32'd0);
    expect_reg("rst_status", 5'h04, 32'd0);
    expect_reg("rst_bufsize", 5'h0C, 32'd0);

    // Register access: alignment, byte lanes, unmapped
    wb_write(5'h08, 32'h1234_567B);
    expect_reg("startadr_align", 5'h08, 32'h1234_5678);
    wb_write(5'h08, 32'hAABB_CCDD, 4'b0010);
    expect_reg("startadr_sel", 5'h08, 32'h1234_CC78);
    wb_write(5'h10, 32'h0000_01F3);
    expect_reg("burst_rd", 5'h10, 32'h0000_00F3);
    expect_reg("unmapped_rd", 5'h14, 32'd0);

    // T1: two full bursts at full rate
    ready_mode = 0; ack_rand = 1'b0;
    start_xfer(32'h0000_1000, 8, 4, 32'h0000_A000);
    wait_irq("t1_done", 20);
    check("t1_latency", 32'((first_val - first_ack) <= 2), 32'd1);
    finish_xfer("t1");

    // T2: 4 + 4 + 2
    start_xfer(32'h0000_8000, 10, 4, $urandom);
    wait_irq("t2_done", 40);
    finish_xfer("t2");

    // T3: back-pressure stalls master at FIFO capacity; busy start ignored
    ready_mode = 1;
    base = $urandom;
    start_xfer(32'h0000_2000, 300, 16, base);
    repeat (400) @(negedge clk);
    check("t3_words_stalled", 32'(beat_cnt), 32'd128);
    check("t3_cyc_idle", 32'(wbm_cyc_o), 32'd0);
    check("t3_valid_held", 32'(s_valid), 32'd1);
    check("t3_data_held", s_data, base);
    wb_write(5'h08, 32'hDEAD_0000);
    wb_write(5'h0C, 32'd5);
    wb_write(5'h10, 32'd1);
    wb_write(5'h00, 32'd1);
    expect_reg("t3_busy", 5'h00, 32'd1);
    expect_reg("t3_rewrite", 5'h08, 32'hDEAD_0000);
    ready_mode = 2;
    wait_irq("t3_done", 3000);
    check("t3_total_beats", 32'(beat_cnt), 32'd300);
    finish_xfer("t3");

    // Randomized transfers with stalls on both sides, one wrapping the address space
    ack_rand = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sa = (i == 3) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
      start_xfer(sa, $urandom_range(1, 40), $urandom_range(0, 20), $urandom);
      wait_irq("rnd_done", 1000);
      finish_xfer("rnd");
    end

    // Bus error on the third beat
    ack_rand = 1'b0; ready_mode = 1; hold_en = 1'b0; err_at = 3;
    start_xfer(32'h0000_3000, 8, 4, $urandom);
    n = 0;
    while (!(wbm_err_i && wbm_cyc_o) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("err_seen", 32'(wbm_err_i), 32'd1);
    @(negedge clk);
    check("err_cyc", 32'(wbm_cyc_o), 32'd0);
    check("err_stb", 32'(wbm_stb_o), 32'd0);
    check("err_valid", 32'(s_valid), 32'd0);
    check("err_irq", 32'(irq_o), 32'd1);
    check("err_beats", 32'(beat_cnt), 32'd2);
    err_at = 0;
    clear_model();
    expect_reg("err_status", 5'h04, 32'd2);
    wb_write(5'h04, 32'd2);
    check("err_irq_clr", 32'(irq_o), 32'd0);
    hold_en = 1'b1; ready_mode = 0;

    // Zero-length buffer
    cyc_seen = 1'b0;
    wb_write(5'h0C, 32'd0);
    wb_write(5'h00, 32'd1);
    check("zero_irq", 32'(irq_o), 32'd1);
    repeat (3) @(negedge clk);
    check("zero_no_cyc", 32'(cyc_seen), 32'd0);
    expect_reg("zero_status", 5'h04, 32'd1);
    wb_write(5'h04, 32'd1);

    // Reset in the middle of a burst, then a fresh transfer
    ready_mode = 2;
    start_xfer(32'h0000_4000, 64, 16, $urandom);
    n = 0;
    while (!wbm_cyc_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_cyc", 32'(wbm_cyc_o), 32'd0);
    check("mrst_stb", 32'(wbm_stb_o), 32'd0);
    check("mrst_valid", 32'(s_valid), 32'd0);
    check("mrst_irq", 32'(irq_o), 32'd0);
    clear_model();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    start_xfer(32'h0000_5000, 20, 8, $urandom);
    wait_irq("mrst_after_done", 400);
    finish_xfer("mrst_after");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
